// File: rtl/seqdet_param.sv
// Serial sync-word detector with a runtime-loadable N-bit pattern, selectable
// overlap and Moore/Mealy output timing, plus a saturating detection counter.
module seqdet_param #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1101,
  parameter bit                 OVERLAP  = 1'b0,
  parameter bit                 MOORE    = 1'b1,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic               i_data,
  input  logic               i_pat_we,
  input  logic [PAT_LEN-1:0] i_pattern,
  input  logic               i_cnt_clr,
  output logic               o_det,
  output logic [CNT_W-1:0]   o_count,
  output logic [PAT_LEN-1:0] o_pattern
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);

  // Only the N-1 most recent bits are stored; the newest bit completes the window.
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] pat;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic [PAT_LEN-1:0] window;
  logic               match;

  assign accept = i_valid & ~i_pat_we & ~reset;
  assign window = {hist, i_data};
  assign match  = accept && (fill >= FILL_THR) && (window == pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= PAT_INIT;
    end else if (i_pat_we) begin
      pat  <= i_pattern;
      fill <= '0;
    end else if (accept) begin
      hist <= window[PAT_LEN-2:0];
      if (match && !OVERLAP)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_cnt_clr)
      cnt <= '0;
    else if (match && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  generate
    if (MOORE) begin : g_moore
      logic det_q;
      always_ff @(posedge clk) begin
        if (reset) det_q <= 1'b0;
        else       det_q <= match;
      end
      assign o_det = det_q;
    end else begin : g_mealy
      assign o_det = match;
    end
  endgenerate

  assign o_count   = cnt;
  assign o_pattern = pat;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed bench for seqdet_param: four parameterisations share one stimulus
// bus; expected detections are queued at drive time and popped on output.
module tb_seqdet_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid, i_data, i_pat_we, i_cnt_clr;
  logic [3:0] i_pattern;

  logic       def_det, ovl_det, mea_det, sat_det;
  logic [7:0] def_cnt, ovl_cnt, mea_cnt;
  logic [1:0] sat_cnt;
  logic [3:0] def_pat, ovl_pat, mea_pat, sat_pat;

  always #5 clk = ~clk;

  seqdet_param u_def (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .i_pat_we(i_pat_we), .i_pattern(i_pattern), .i_cnt_clr(i_cnt_clr),
    .o_det(def_det), .o_count(def_cnt), .o_pattern(def_pat));

  seqdet_param #(.OVERLAP(1'b1)) u_ovl (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .i_pat_we(i_pat_we), .i_pattern(i_pattern), .i_cnt_clr(i_cnt_clr),
    .o_det(ovl_det), .o_count(ovl_cnt), .o_pattern(ovl_pat));

  seqdet_param #(.MOORE(1'b0)) u_mea (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .i_pat_we(i_pat_we), .i_pattern(i_pattern), .i_cnt_clr(i_cnt_clr),
    .o_det(mea_det), .o_count(mea_cnt), .o_pattern(mea_pat));

  seqdet_param #(.CNT_W(2), .OVERLAP(1'b1), .PAT_INIT(4'b1111)) u_sat (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .i_pat_we(i_pat_we), .i_pattern(i_pattern), .i_cnt_clr(i_cnt_clr),
    .o_det(sat_det), .o_count(sat_cnt), .o_pattern(sat_pat));

  typedef struct {
    logic        det;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          sel;
  int          cmax;
  int          ecnt;
  int          total;
  int          bad;
  logic        cur_det;
  logic [31:0] cur_cnt;

  always_comb begin
    cur_det = 1'b0;
    cur_cnt = '0;
    case (sel)
      0: begin cur_det = def_det; cur_cnt = 32'(def_cnt); end
      1: begin cur_det = ovl_det; cur_cnt = 32'(ovl_cnt); end
      2: begin cur_det = mea_det; cur_cnt = 32'(mea_cnt); end
      3: begin cur_det = sat_det; cur_cnt = 32'(sat_cnt); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; called and returning just after a rising edge.
  task automatic step(input logic v, input logic d, input logic we, input logic clr,
                      input logic edet, input string tag);
    exp_t e;
    i_valid = v; i_data = d; i_pat_we = we; i_cnt_clr = clr;
    @(negedge clk);
    if (sel == 2) begin
      chk({tag, "_det"}, 32'(cur_det), 32'(edet));
      chk({tag, "_cnt"}, cur_cnt, 32'(ecnt));
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_det"}, 32'(cur_det), 32'(e.det));
      chk({tag, "_cnt"}, cur_cnt, e.cnt);
    end
    if (clr) ecnt = 0;
    else if (edet && ecnt < cmax) ecnt++;
    if (sel != 2) begin
      e.det = edet;
      e.cnt = 32'(ecnt);
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Bits and expected detections are listed first-bit-first (MSB side).
  task automatic feed(input logic [15:0] bits, input int n, input logic [15:0] dets,
                      input string tag);
    logic [15:0] b, x;
    b = bits; x = dets;
    for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0, 1'b0, x[i], tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input int s, input int mx);
    reset = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_pat_we = 1'b0; i_cnt_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    ecnt = 0; sel = s; cmax = mx;
    chk("rst_det", 32'(def_det), 32'd0);
    chk("rst_cnt", 32'(def_cnt), 32'd0);
    chk("rst_pat", 32'(def_pat), 32'hd);
    chk("rst_sat_pat", 32'(sat_pat), 32'hf);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; cmax = 255; ecnt = 0;
    reset = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_pat_we = 1'b0;
    i_cnt_clr = 1'b0; i_pattern = 4'b0000;
    repeat (2) @(posedge clk);
    #1;

    // Basic Moore detection, then a run of leading ones before 1101.
    do_reset(0, 255);
    feed(16'b1101, 4, 16'b0001, "t1_basic");
    idle(1, "t1_post");
    chk("t1_count", 32'(def_cnt), 32'd1);
    feed(16'b1111101, 7, 16'b0000001, "t1_run");
    idle(2, "t1_post2");

    // Non-overlapping vs overlapping on 1101101.
    do_reset(0, 255);
    feed(16'b1101101, 7, 16'b0001000, "t2_nov");
    idle(2, "t2_nov_post");
    chk("t2_nov_count", 32'(def_cnt), 32'd1);
    do_reset(1, 255);
    feed(16'b1101101, 7, 16'b0001001, "t2_ovl");
    idle(2, "t2_ovl_post");
    chk("t2_ovl_count", 32'(ovl_cnt), 32'd2);

    // Mealy timing with a 3-cycle valid gap, then load interaction.
    do_reset(2, 255);
    feed(16'b11, 2, 16'b00, "t3_a");
    idle(3, "t3_gap");
    feed(16'b01, 2, 16'b01, "t3_b");
    idle(1, "t3_post");
    i_pattern = 4'b0110;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t3_load");
    chk("t3_pat", 32'(mea_pat), 32'h6);
    feed(16'b011, 3, 16'b000, "t3_pre");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t3_we_valid");
    feed(16'b0110, 4, 16'b0001, "t3_after");
    idle(1, "t3_end");

    // Runtime pattern 0110: old pattern ignored, new one found.
    do_reset(0, 255);
    i_pattern = 4'b0110;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4_load");
    chk("t4_pat", 32'(def_pat), 32'h6);
    feed(16'b11010110, 8, 16'b00000001, "t4_feed");
    idle(2, "t4_post");
    // Bit presented with the load is dropped: no spurious 0110.
    do_reset(0, 255);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t4_we_valid");
    feed(16'b1100110, 7, 16'b0000001, "t4_drop");
    idle(2, "t4_drop_post");

    // 2-bit counter saturation with back-to-back overlapping 1111 hits.
    do_reset(3, 3);
    feed(16'b1111111111, 10, 16'b0001111111, "t5_sat");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_hold");
    chk("t5_sat_count", 32'(sat_cnt), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "t5_clr_match");
    idle(1, "t5_after_clr");
    chk("t5_clr_count", 32'(sat_cnt), 32'd0);

    // Reset mid-pattern discards history.
    do_reset(0, 255);
    feed(16'b110, 3, 16'b000, "t6_pre");
    do_reset(0, 255);
    feed(16'b1, 1, 16'b0, "t6_after");
    idle(2, "t6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
